alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised integer execute unit for the x86-64 core. Accepts one op per cycle from issue over valid/ready.
//  Returns a registered result plus an RFLAGS-format flag word and the issue tag to writeback.
//  Covers add/adc/sub, logic ops, shifts, and an iterative unsigned multiply producing a double-width product.
// PARAMETERS
//  WIDTH  64  datapath width; legal 8/16/32/64
//  TAG_W  6   width of the opaque tag (ROB index) passed through unchanged
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst_n      in   1       synchronous reset, active low
//  in_valid   in   1       op presented this cycle
//  in_ready   out  1       unit can accept; transfer when in_valid&&in_ready
//  in_op      in   4       alu_op_t
//  in_a       in   WIDTH   operand 1 (dest/src for 2-operand x86 form)
//  in_b       in   WIDTH   operand 2 / shift count
//  in_flags   in   64      current RFLAGS (CF carries in for ADC; also the pass-through value)
//  in_tag     in   TAG_W   tag
//  out_valid  out  1       result held until out_valid&&out_ready
//  out_ready  in   1       writeback accepts
//  out_result out  WIDTH   result, or low half of product
//  out_hi     out  WIDTH   high half of product for MUL; 0 for all other ops
//  out_flags  out  64      CF=b0 PF=b2 ZF=b6 SF=b7 OF=b11; all other bits copied from in_flags
//  out_tag    out  TAG_W   tag of the op
//  out_err    out  1       unsupported opcode
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out_valid=0, out_result=0, out_hi=0, out_flags=0, out_tag=0, out_err=0, mul FSM->IDLE.
//  Reset aborts an in-flight MUL; the result is discarded. in_ready=1 in the first cycle after reset.
//  FSM states: IDLE, MUL_BUSY. The output register is a single entry.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; no dependency on in_valid.
//  Non-MUL op accepted at edge N: output register loaded at edge N; visible in cycle N+1 (latency 1).
//    Back-to-back ops sustain 1/cycle while out_ready=1.
//  MUL accepted at edge N: IDLE->MUL_BUSY. One shift-add step per edge.
//    On edge N+WIDTH the output register is loaded and the FSM returns to IDLE. in_ready=0 throughout.
//  Stall: out_valid && !out_ready -> all out_* held stable; no op is accepted.
//  Ops: ADD=0 ADC=1 SUB=2 AND=3 OR=4 XOR=5 SHL=6 SHR=7 SAR=8 MUL=9; 10..15 unsupported.
//  Arithmetic: computed at WIDTH+1 bits. ADC adds in_flags[0].
//    ADD/ADC: CF = carry out. SUB: CF = borrow.
//    OF = signed overflow (operand sign bits equal and differ from result sign; for SUB, relative to a and ~b).
//  Logic ops: CF=OF=0.
//  Shifts: count = in_b & (WIDTH==64 ? 63 : 31).
//    count==0: result=in_a, out_flags=in_flags unchanged.
//    Otherwise CF = last bit shifted out.
//    OF for count==1: SHL = res[MSB]^CF; SHR = in_a[MSB]; SAR = 0. OF = 0 for count>1.
//    count>=WIDTH (WIDTH<32 only): result 0 for SHL/SHR, sign fill for SAR; CF=0 for SHL/SHR.
//  MUL: unsigned {out_hi,out_result} = a*b. CF=OF=(out_hi!=0).
//  ZF/SF/PF for all ops except MUL and count==0 shifts:
//    ZF=(result==0), SF=result[MSB], PF=~^result[7:0]. MUL sets these from out_result.
//  Unsupported op: latency 1, out_err=1, result=0, out_hi=0, out_flags=in_flags. Never $display/halt.
//  Tag, err and flags always travel with their result.
// STRUCTURE
//  alu_pkg: alu_op_t enum (4b, values above) and RFLAGS bit-index localparams (CF_B, PF_B, ZF_B, SF_B, OF_B).
//  Include alu_pkg from instruction.svh so that opcode_t decode maps onto it.
//  Sub-module alu_mul_iter: WIDTH-step shift-add multiplier with start/done handshake and rst_n abort.
//  Combinational op/flag logic stays in alu_pipe.
// TESTING (WIDTH=64)
//  1. ADD a=64'hFFFF_FFFF_FFFF_FFFF b=1 -> result 0, CF=1 ZF=1 PF=1 SF=0 OF=0, out_valid the next cycle.
//  2. SUB a=64'h8000_0000_0000_0000 b=1 -> 64'h7FFF_FFFF_FFFF_FFFF, OF=1 CF=0 SF=0 ZF=0.
//     ADC 1+1 with in_flags[0]=1 -> 3.
//  3. MUL a=b=64'h1_0000_0000 -> out_result=0, out_hi=1, CF=OF=1.
//     in_ready=0 for 64 cycles; out_valid exactly 64 cycles after accept.
//  4. SHL a=64'h8000_0000_0000_0000 b=1 -> 0, CF=1 OF=1 ZF=1.
//     SHL b=64 (masked to 0) -> result=a, out_flags==in_flags.
//  5. Stream 4 ADDs with out_ready low for cycles 2-4:
//     first result held stable, in_ready=0 while stalled, no loss/duplication, tags in order.
//  6. rst_n=0 at MUL step 10 -> out_valid=0, in_ready=1 the next cycle, no stale result.
//     op=4'hF -> out_err=1, flags pass-through.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and RFLAGS bit positions for the
// integer execute unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_SAR = 4'd8,
        OP_MUL = 4'd9
    } alu_op_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_t;

    localparam int CF_B = 0;
    localparam int PF_B = 2;
    localparam int ZF_B = 6;
    localparam int SF_B = 7;
    localparam int OF_B = 11;

    // x86 PF is set when the low byte holds an even number of ones.
    function automatic logic parity_even(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one step per clock, WIDTH steps.
// The final step's product is presented combinationally alongside done.
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    // lo starts as the multiplier and fills with product bits from the top.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        next_hi = sum[WIDTH:1];
        next_lo = {sum[0], lo[WIDTH-1:1]};
    end

    assign done    = busy && (cnt == LAST);
    assign prod_hi = next_hi;
    assign prod_lo = next_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            mcand <= a;
            hi    <= '0;
            lo    <= b;
        end else if (busy) begin
            hi  <= next_hi;
            lo  <= next_lo;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Integer execute unit: single-cycle add/logic/shift ops, iterative multiply,
// one-entry registered output carrying result, RFLAGS word, tag and error.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [63:0]      in_flags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_hi,
    output logic [63:0]      out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output alu_state_t       dbg_state
);

    localparam int MSB = WIDTH - 1;
    localparam logic [5:0] CNT_MASK = (WIDTH == 64) ? 6'd63 : 6'd31;

    // Handshake: a beat moves on either side only when valid && ready at posedge.
    // in_ready never looks at in_valid; out_* hold stable while out_valid && !out_ready.
    alu_state_t       state;
    logic             fire_in;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [TAG_W-1:0] mul_tag;
    logic [63:0]      mul_flags;
    logic [63:0]      mul_out_flags;

    logic [WIDTH-1:0]   alu_res;
    logic [63:0]        alu_flags;
    logic               alu_err;
    logic               alu_cf;
    logic               alu_of;
    logic               alu_pass;
    logic [WIDTH:0]     arith;
    logic [2*WIDTH-1:0] wide;
    logic [5:0]         cnt;
    logic               big_shift;

    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign fire_in   = in_valid && in_ready;
    assign is_mul    = (in_op == OP_MUL);
    assign dbg_state = state;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (fire_in && is_mul),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .prod_hi (mul_hi),
        .prod_lo (mul_lo)
    );

    always_comb begin
        alu_res   = '0;
        alu_cf    = 1'b0;
        alu_of    = 1'b0;
        alu_err   = 1'b0;
        alu_pass  = 1'b0;
        arith     = '0;
        wide      = '0;
        cnt       = in_b[5:0] & CNT_MASK;
        big_shift = int'(cnt) >= WIDTH;
        case (in_op)
            OP_ADD, OP_ADC: begin
                arith   = {1'b0, in_a} + {1'b0, in_b}
                        + {{WIDTH{1'b0}}, (in_op == OP_ADC) & in_flags[CF_B]};
                alu_res = arith[WIDTH-1:0];
                alu_cf  = arith[WIDTH];
                alu_of  = (in_a[MSB] == in_b[MSB]) && (alu_res[MSB] != in_a[MSB]);
            end
            OP_SUB: begin
                arith   = {1'b0, in_a} - {1'b0, in_b};
                alu_res = arith[WIDTH-1:0];
                alu_cf  = arith[WIDTH];
                alu_of  = (in_a[MSB] != in_b[MSB]) && (alu_res[MSB] != in_a[MSB]);
            end
            OP_AND: alu_res = in_a & in_b;
            OP_OR:  alu_res = in_a | in_b;
            OP_XOR: alu_res = in_a ^ in_b;
            // Shifts run in a double-width window so the last bit out lands at a fixed index.
            OP_SHL: begin
                if (cnt == 6'd0) begin
                    alu_res  = in_a;
                    alu_pass = 1'b1;
                end else if (!big_shift) begin
                    wide    = {{WIDTH{1'b0}}, in_a} << cnt;
                    alu_res = wide[WIDTH-1:0];
                    alu_cf  = wide[WIDTH];
                    alu_of  = (cnt == 6'd1) ? (alu_res[MSB] ^ alu_cf) : 1'b0;
                end
            end
            OP_SHR: begin
                if (cnt == 6'd0) begin
                    alu_res  = in_a;
                    alu_pass = 1'b1;
                end else if (!big_shift) begin
                    wide    = {in_a, {WIDTH{1'b0}}} >> cnt;
                    alu_res = wide[2*WIDTH-1:WIDTH];
                    alu_cf  = wide[WIDTH-1];
                    alu_of  = (cnt == 6'd1) ? in_a[MSB] : 1'b0;
                end
            end
            OP_SAR: begin
                if (cnt == 6'd0) begin
                    alu_res  = in_a;
                    alu_pass = 1'b1;
                end else if (big_shift) begin
                    alu_res = {WIDTH{in_a[MSB]}};
                    alu_cf  = in_a[MSB];
                end else begin
                    wide    = $unsigned($signed({in_a, {WIDTH{1'b0}}}) >>> cnt);
                    alu_res = wide[2*WIDTH-1:WIDTH];
                    alu_cf  = wide[WIDTH-1];
                end
            end
            OP_MUL: alu_res = '0;
            default: begin
                alu_err  = 1'b1;
                alu_pass = 1'b1;
            end
        endcase

        alu_flags = in_flags;
        if (!alu_pass) begin
            alu_flags[CF_B] = alu_cf;
            alu_flags[OF_B] = alu_of;
            alu_flags[ZF_B] = (alu_res == '0);
            alu_flags[SF_B] = alu_res[MSB];
            alu_flags[PF_B] = parity_even(alu_res[7:0]);
        end
    end

    always_comb begin
        mul_out_flags       = mul_flags;
        mul_out_flags[CF_B] = |mul_hi;
        mul_out_flags[OF_B] = |mul_hi;
        mul_out_flags[ZF_B] = (mul_lo == '0);
        mul_out_flags[SF_B] = mul_lo[MSB];
        mul_out_flags[PF_B] = parity_even(mul_lo[7:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mul_tag    <= '0;
            mul_flags  <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_hi     <= '0;
            out_flags  <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire_in && is_mul) begin
                        state     <= ST_MUL_BUSY;
                        mul_tag   <= in_tag;
                        mul_flags <= in_flags;
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_done) state <= ST_IDLE;
                end
            endcase

            // The output slot is always free when a multiply finishes: it was
            // drained or empty when the multiply was accepted.
            if (mul_done) begin
                out_valid  <= 1'b1;
                out_result <= mul_lo;
                out_hi     <= mul_hi;
                out_flags  <= mul_out_flags;
                out_tag    <= mul_tag;
                out_err    <= 1'b0;
            end else if (fire_in && !is_mul) begin
                out_valid  <= 1'b1;
                out_result <= alu_res;
                out_hi     <= '0;
                out_flags  <= alu_flags;
                out_tag    <= in_tag;
                out_err    <= alu_err;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=64 with hand-computed expectations.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [63:0] in_flags;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [63:0] out_hi;
    logic [63:0] out_flags;
    logic [5:0]  out_tag;
    logic        out_err;
    alu_state_t  dbg_state;

    int checks   = 0;
    int failures = 0;

    alu_pipe #(.WIDTH(64), .TAG_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_flags   (in_flags),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_hi     (out_hi),
        .out_flags  (out_flags),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .dbg_state  (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the op accepted.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] flags, input logic [5:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_flags = flags;
        in_tag   = tag;
        #1;
        check("issue_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [63:0] got_res[$];
    logic [5:0]  got_tag[$];
    logic [63:0] hold_res;
    logic [5:0]  hold_tag;
    int          sent;
    int          c;
    int          cycles;
    logic        ready_leak;
    logic        stale;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = '0;
        in_b      = '0;
        in_flags  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid",  {63'd0, out_valid}, 64'd0);
        check("rst_result", out_result, 64'd0);
        check("rst_hi",     out_hi, 64'd0);
        check("rst_flags",  out_flags, 64'd0);
        check("rst_tag",    {58'd0, out_tag}, 64'd0);
        check("rst_err",    {63'd0, out_err}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready",  {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        // ADD wraps to zero
        issue(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h202, 6'd1);
        check("add_valid",  {63'd0, out_valid}, 64'd1);
        check("add_result", out_result, 64'd0);
        check("add_flags",  out_flags, 64'h247);
        check("add_tag",    {58'd0, out_tag}, 64'd1);
        check("add_hi",     out_hi, 64'd0);

        issue(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h202, 6'd2);
        check("sub_result", out_result, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_flags",  out_flags, 64'hA06);

        issue(OP_ADC, 64'd1, 64'd1, 64'h203, 6'd3);
        check("adc_result", out_result, 64'd3);
        check("adc_flags",  out_flags, 64'h206);

        issue(OP_XOR, 64'hFF00, 64'h0FF0, 64'h203, 6'd4);
        check("xor_result", out_result, 64'hF0F0);
        check("xor_flags",  out_flags, 64'h206);

        // MUL: 64-cycle latency, in_ready low throughout
        issue(OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 64'h202, 6'd5);
        check("mul_state", {63'd0, dbg_state == ST_MUL_BUSY}, 64'd1);
        cycles     = 0;
        ready_leak = 1'b0;
        while (!out_valid && cycles < 200) begin
            if (in_ready) ready_leak = 1'b1;
            @(negedge clk);
            cycles++;
        end
        check("mul_ready_low", {63'd0, ready_leak}, 64'd0);
        check("mul_latency",   64'(cycles), 64'd64);
        check("mul_result",    out_result, 64'd0);
        check("mul_hi",        out_hi, 64'd1);
        check("mul_flags",     out_flags, 64'hA47);
        check("mul_tag",       {58'd0, out_tag}, 64'd5);

        issue(OP_SHL, 64'h8000_0000_0000_0000, 64'd1, 64'h202, 6'd6);
        check("shl_result", out_result, 64'd0);
        check("shl_flags",  out_flags, 64'hA47);
        check("shl_hi",     out_hi, 64'd0);

        issue(OP_SHL, 64'h1234, 64'd64, 64'h8D5, 6'd7);
        check("shl0_result", out_result, 64'h1234);
        check("shl0_flags",  out_flags, 64'h8D5);

        issue(OP_SAR, 64'h8000_0000_0000_0003, 64'd1, 64'h202, 6'd8);
        check("sar_result", out_result, 64'hC000_0000_0000_0001);
        check("sar_flags",  out_flags, 64'h283);

        issue(OP_SHR, 64'h8000_0000_0000_0000, 64'd1, 64'h0, 6'd9);
        check("shr_result", out_result, 64'h4000_0000_0000_0000);
        check("shr_flags",  out_flags, 64'h804);

        // Stream 4 ADDs, out_ready low in cycles 2-4
        @(negedge clk);
        sent = 0;
        c    = 0;
        while (got_res.size() < 4 && c < 40) begin
            out_ready = !(c >= 2 && c <= 4);
            if (sent < 4) begin
                in_valid = 1'b1;
                in_op    = OP_ADD;
                in_a     = 64'h11 + 64'(sent) * 64'h100;
                in_b     = 64'h22;
                in_flags = 64'h0;
                in_tag   = 6'(10 + sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                hold_res = out_result;
                hold_tag = out_tag;
            end
            if (c >= 2 && c <= 4) begin
                check("stall_ready", {63'd0, in_ready}, 64'd0);
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_res",   out_result, hold_res);
                check("stall_tag",   {58'd0, out_tag}, {58'd0, hold_tag});
            end
            if (out_valid && out_ready) begin
                got_res.push_back(out_result);
                got_tag.push_back(out_tag);
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(got_res.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_res.size()) begin
                check("stream_res", got_res[i], 64'h33 + 64'(i) * 64'h100);
                check("stream_tag", {58'd0, got_tag[i]}, 64'(10 + i));
            end
        end
        check("stream_hold_tag", {58'd0, hold_tag}, 64'd11);

        // Reset in the middle of a MUL
        @(negedge clk);
        issue(OP_MUL, 64'd3, 64'd5, 64'h0, 6'd20);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_ready", {63'd0, in_ready}, 64'd1);
        check("abort_state", {63'd0, dbg_state == ST_MUL_BUSY}, 64'd0);
        stale = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("abort_no_stale", {63'd0, stale}, 64'd0);

        issue(4'hF, 64'd5, 64'd7, 64'h8D5, 6'd33);
        check("err_flag",   {63'd0, out_err}, 64'd1);
        check("err_result", out_result, 64'd0);
        check("err_hi",     out_hi, 64'd0);
        check("err_flags",  out_flags, 64'h8D5);
        check("err_tag",    {58'd0, out_tag}, 64'd33);

        issue(OP_ADD, 64'd2, 64'd3, 64'h0, 6'd34);
        check("post_err_flag",   {63'd0, out_err}, 64'd0);
        check("post_err_result", out_result, 64'd5);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
